// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : RV32I opcode, ALU-code and imm-select constants plus the decoded
//            control bundle shared by ctrl_decode and decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;

    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    localparam logic [3:0] c_alu_and   = 4'b0001;
    localparam logic [3:0] c_alu_or    = 4'b0010;
    localparam logic [3:0] c_alu_xor   = 4'b0011;
    localparam logic [3:0] c_alu_add   = 4'b0100;
    localparam logic [3:0] c_alu_sll   = 4'b0101;
    localparam logic [3:0] c_alu_srl   = 4'b0110;
    localparam logic [3:0] c_alu_sra   = 4'b0111;
    localparam logic [3:0] c_alu_sub   = 4'b1000;
    localparam logic [3:0] c_alu_slt   = 4'b1001;
    localparam logic [3:0] c_alu_sltu  = 4'b1010;
    localparam logic [3:0] c_alu_passb = 4'b1011;
    localparam logic [3:0] c_alu_mul   = 4'b1100;
    localparam logic [3:0] c_alu_mulh  = 4'b1101;
    localparam logic [3:0] c_alu_div   = 4'b1110;
    localparam logic [3:0] c_alu_rem   = 4'b1111;

    localparam logic [2:0] c_imm_i     = 3'b000;
    localparam logic [2:0] c_imm_s     = 3'b001;
    localparam logic [2:0] c_imm_b     = 3'b010;
    localparam logic [2:0] c_imm_u     = 3'b011;
    localparam logic [2:0] c_imm_j     = 3'b100;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_bundle_t;

    // Idle bundle: also the reset value and the base of every illegal decode.
    localparam ctrl_bundle_t c_bundle_nop = '{
        imm_sel:    c_imm_i,
        alu_ctrl:   c_alu_add,
        reg_write:  1'b0,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        jump:       1'b0,
        illegal:    1'b0
    };

    // funct3 -> ALU code for the base (funct7 = 0) register/immediate ops.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return c_alu_add;
            3'b001:  return c_alu_sll;
            3'b010:  return c_alu_slt;
            3'b011:  return c_alu_sltu;
            3'b100:  return c_alu_xor;
            3'b101:  return c_alu_srl;
            3'b110:  return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

    // Signed/unsigned M-extension variants share one ALU code per class.
    function automatic logic [3:0] muldiv_alu(input logic [2:0] funct3);
        case (funct3)
            3'b000:                 return c_alu_mul;
            3'b001, 3'b010, 3'b011: return c_alu_mulh;
            3'b100, 3'b101:         return c_alu_div;
            default:                return c_alu_rem;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational RV32I control decode (M ops when DECODE_MULDIV_EN
//            is defined) with source-register usage flags.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output logic         uses_rs1,
    output logic         uses_rs2
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_illegal;
    logic       w_unused_fields;

    assign w_opcode        = instr[6:0];
    assign w_funct3        = instr[14:12];
    assign w_funct7        = instr[31:25];
    assign w_unused_fields = ^instr[24:15] ^ ^instr[11:7];

    always_comb begin
        bundle    = c_bundle_nop;
        w_illegal = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        case (w_opcode)
            c_op_reg: begin
                bundle.reg_write = 1'b1;
                uses_rs2         = 1'b1;
                if (w_funct7 == c_f7_base)
                    bundle.alu_ctrl = alu_from_funct3(w_funct3);
                else if (w_funct7 == c_f7_alt && w_funct3 == 3'b000)
                    bundle.alu_ctrl = c_alu_sub;
                else if (w_funct7 == c_f7_alt && w_funct3 == 3'b101)
                    bundle.alu_ctrl = c_alu_sra;
`ifdef DECODE_MULDIV_EN
                else if (w_funct7 == c_f7_muldiv)
                    bundle.alu_ctrl = muldiv_alu(w_funct3);
`endif
                else
                    w_illegal = 1'b1;
            end
            c_op_imm: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_ctrl  = alu_from_funct3(w_funct3);
                // Only shift-immediates reuse funct7 as an opcode extension.
                if (w_funct3 == 3'b001 && w_funct7 != c_f7_base)
                    w_illegal = 1'b1;
                else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == c_f7_alt)
                        bundle.alu_ctrl = c_alu_sra;
                    else if (w_funct7 != c_f7_base)
                        w_illegal = 1'b1;
                end
            end
            c_op_load: begin
                bundle.reg_write  = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.mem_read   = 1'b1;
                bundle.mem_to_reg = 1'b1;
            end
            c_op_store: begin
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
                bundle.imm_sel   = c_imm_s;
                uses_rs2         = 1'b1;
            end
            c_op_branch: begin
                bundle.branch   = 1'b1;
                bundle.alu_ctrl = c_alu_sub;
                bundle.imm_sel  = c_imm_b;
                uses_rs2        = 1'b1;
            end
            c_op_lui: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_ctrl  = c_alu_passb;
                bundle.imm_sel   = c_imm_u;
                uses_rs1         = 1'b0;
            end
            c_op_auipc: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.imm_sel   = c_imm_u;
                uses_rs1         = 1'b0;
            end
            c_op_jal: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.jump      = 1'b1;
                bundle.imm_sel   = c_imm_j;
                uses_rs1         = 1'b0;
            end
            c_op_jalr: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.jump      = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            bundle         = c_bundle_nop;
            bundle.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered decode stage with valid/ready handshake, flush and a
//            one-cycle load-use stall. M ops enabled by DECODE_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_imm_sel,
    output logic [ALU_W-1:0] out_alu_ctrl,
    output logic             out_reg_write,
    output logic             out_alu_src,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_mem_to_reg,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_illegal
);

    ctrl_bundle_t    w_dec;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_load;

    ctrl_bundle_t    r_bundle;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic            r_valid;
    logic            r_lu_valid;
    logic [4:0]      r_lu_rd;

    ctrl_decode u_ctrl_decode (
        .instr    (in_instr),
        .bundle   (w_dec),
        .uses_rs1 (w_uses_rs1),
        .uses_rs2 (w_uses_rs2)
    );

    assign w_rd  = in_instr[11:7];
    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];

    assign w_hazard   = in_valid && r_lu_valid &&
                        ((w_uses_rs1 && (w_rs1 == r_lu_rd)) ||
                         (w_uses_rs2 && (w_rs2 == r_lu_rd)));
    assign w_in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_load     = in_valid && w_in_ready;

    // The tracker is armed as a load enters the output register and lives for
    // exactly one cycle, so a back-to-back consumer is held off once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_lu_valid <= 1'b0;
            r_lu_rd    <= 5'd0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_lu_valid <= 1'b0;
        end else begin
            r_lu_valid <= w_load && w_dec.mem_read && (w_rd != 5'd0);
            if (w_load) begin
                r_lu_rd <= w_rd;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle <= c_bundle_nop;
            r_pc     <= '0;
            r_rd     <= 5'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
        end else if (w_load) begin
            r_bundle <= w_dec;
            r_pc     <= in_pc;
            r_rd     <= w_rd;
            r_rs1    <= w_rs1;
            r_rs2    <= w_rs2;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_rd         = r_rd;
    assign out_rs1        = r_rs1;
    assign out_rs2        = r_rs2;
    assign out_imm_sel    = r_bundle.imm_sel;
    assign out_alu_ctrl   = ALU_W'(r_bundle.alu_ctrl);
    assign out_reg_write  = r_bundle.reg_write;
    assign out_alu_src    = r_bundle.alu_src;
    assign out_mem_read   = r_bundle.mem_read;
    assign out_mem_write  = r_bundle.mem_write;
    assign out_mem_to_reg = r_bundle.mem_to_reg;
    assign out_branch     = r_bundle.branch;
    assign out_jump       = r_bundle.jump;
    assign out_illegal    = r_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench: directed decode table, hand-written handshake
//            sequences and a random stream against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

`ifdef DECODE_MULDIV_EN
    localparam bit c_muldiv = 1'b1;
`else
    localparam bit c_muldiv = 1'b0;
`endif

    typedef struct packed {
        logic       ill;
        logic       rw;
        logic       asrc;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       br;
        logic       jp;
        logic [2:0] imm;
        logic [3:0] alu;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_imm_sel;
    logic [3:0]  out_alu_ctrl;
    logic        out_reg_write, out_alu_src, out_mem_read, out_mem_write;
    logic        out_mem_to_reg, out_branch, out_jump, out_illegal;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: what the output register should hold.
    logic        m_valid = 1'b0;
    dec_t        m_dec;
    logic [31:0] m_pc;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic        m_lu = 1'b0;
    logic [4:0]  m_lu_rd = 5'd0;

    vec_t tab[$];

    decode_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_imm_sel    (out_imm_sel),
        .out_alu_ctrl   (out_alu_ctrl),
        .out_reg_write  (out_reg_write),
        .out_alu_src    (out_alu_src),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_branch     (out_branch),
        .out_jump       (out_jump),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    // flags order: ill rw asrc mr mw m2r br jp
    function automatic dec_t mk(input logic [7:0] flags, input logic [2:0] imm, input logic [3:0] alu);
        return {flags, imm, alu};
    endfunction

    function automatic dec_t dut_dec();
        return {out_illegal, out_reg_write, out_alu_src, out_mem_read, out_mem_write,
                out_mem_to_reg, out_branch, out_jump, out_imm_sel, out_alu_ctrl};
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] base;
        logic       bad;
        dec_t       d;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        bad = 1'b0;
        d   = mk(8'b0, 3'b000, 4'b0100);
        case (f3)
            3'd0: base = 4'b0100;
            3'd1: base = 4'b0101;
            3'd2: base = 4'b1001;
            3'd3: base = 4'b1010;
            3'd4: base = 4'b0011;
            3'd5: base = 4'b0110;
            3'd6: base = 4'b0010;
            default: base = 4'b0001;
        endcase
        case (op)
            7'h33: begin
                d.rw = 1'b1;
                if (f7 == 7'h00)                   d.alu = base;
                else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'b1000;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'b0111;
                else if (f7 == 7'h01 && c_muldiv)
                    d.alu = (f3 == 3'd0) ? 4'b1100 : (f3 < 3'd4) ? 4'b1101 :
                            (f3 < 3'd6) ? 4'b1110 : 4'b1111;
                else bad = 1'b1;
            end
            7'h13: begin
                d.rw = 1'b1; d.asrc = 1'b1; d.alu = base;
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      d.alu = 4'b0111;
                    else if (f7 != 7'h00) bad = 1'b1;
                end
            end
            7'h03: begin d.rw = 1'b1; d.asrc = 1'b1; d.mr = 1'b1; d.m2r = 1'b1; end
            7'h23: begin d.asrc = 1'b1; d.mw = 1'b1; d.imm = 3'b001; end
            7'h63: begin d.br = 1'b1; d.imm = 3'b010; d.alu = 4'b1000; end
            7'h37: begin d.rw = 1'b1; d.asrc = 1'b1; d.imm = 3'b011; d.alu = 4'b1011; end
            7'h17: begin d.rw = 1'b1; d.asrc = 1'b1; d.imm = 3'b011; end
            7'h6F: begin d.rw = 1'b1; d.asrc = 1'b1; d.jp = 1'b1; d.imm = 3'b100; end
            7'h67: begin d.rw = 1'b1; d.asrc = 1'b1; d.jp = 1'b1; end
            default: bad = 1'b1;
        endcase
        if (bad) d = mk(8'b1000_0000, 3'b000, 4'b0100);
        return d;
    endfunction

    function automatic logic exp_ready();
        logic [6:0] op;
        logic       u1, u2, hz;
        op = in_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        hz = in_valid && m_lu && ((u1 && in_instr[19:15] == m_lu_rd) ||
                                  (u2 && in_instr[24:20] == m_lu_rd));
        return (!m_valid || out_ready) && !hz && !flush;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [6:0] f7;
        case ($urandom_range(0, 10))
            0, 1: op = 7'h33;
            2:    op = 7'h13;
            3:    op = 7'h03;
            4:    op = 7'h23;
            5:    op = 7'h63;
            6:    op = 7'h37;
            7:    op = 7'h17;
            8:    op = 7'h6F;
            9:    op = 7'h67;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_ctrl"}, dut_dec(), mk(8'b0, 3'b000, 4'b0100));
        chk({name, "_pc"}, out_pc, 32'h0);
        chk({name, "_fields"}, {out_rd, out_rs1, out_rs2}, 15'h0);
    endtask

    // Mid-cycle comparison of DUT against the model.
    task automatic mid();
        @(negedge clk);
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("ctrl", dut_dec(), m_dec);
            chk("out_pc", out_pc, m_pc);
            chk("fields", {out_rd, out_rs1, out_rs2}, {m_rd, m_rs1, m_rs2});
        end
    endtask

    // Advance one rising edge, updating the model from the stage rules.
    task automatic adv();
        logic rdy;
        rdy = exp_ready();
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_lu    = 1'b0;
        end else begin
            m_lu = 1'b0;
            if (in_valid && rdy) begin
                m_valid = 1'b1;
                m_dec   = ref_dec(in_instr);
                m_pc    = in_pc;
                m_rd    = in_instr[11:7];
                m_rs1   = in_instr[19:15];
                m_rs2   = in_instr[24:20];
                if (in_instr[6:0] == 7'h03 && in_instr[11:7] != 5'd0) begin
                    m_lu    = 1'b1;
                    m_lu_rd = in_instr[11:7];
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick();
        mid();
        adv();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        dec_t ill;
        ill = mk(8'b1000_0000, 3'b000, 4'b0100);
        tab.push_back('{32'h002081B3, mk(8'b0100_0000, 3'b000, 4'b0100)}); // add
        tab.push_back('{32'h402081B3, mk(8'b0100_0000, 3'b000, 4'b1000)}); // sub
        tab.push_back('{32'h002091B3, mk(8'b0100_0000, 3'b000, 4'b0101)}); // sll
        tab.push_back('{32'h0020A1B3, mk(8'b0100_0000, 3'b000, 4'b1001)}); // slt
        tab.push_back('{32'h0020B1B3, mk(8'b0100_0000, 3'b000, 4'b1010)}); // sltu
        tab.push_back('{32'h0020C1B3, mk(8'b0100_0000, 3'b000, 4'b0011)}); // xor
        tab.push_back('{32'h0020D1B3, mk(8'b0100_0000, 3'b000, 4'b0110)}); // srl
        tab.push_back('{32'h4020D1B3, mk(8'b0100_0000, 3'b000, 4'b0111)}); // sra
        tab.push_back('{32'h0020E1B3, mk(8'b0100_0000, 3'b000, 4'b0010)}); // or
        tab.push_back('{32'h4020F1B3, ill});                               // and, bad funct7
        tab.push_back('{32'h00510093, mk(8'b0110_0000, 3'b000, 4'b0100)}); // addi
        tab.push_back('{32'h40315093, mk(8'b0110_0000, 3'b000, 4'b0111)}); // srai
        tab.push_back('{32'h40311093, ill});                               // slli, bad funct7
        tab.push_back('{32'h0000A283, mk(8'b0111_0100, 3'b000, 4'b0100)}); // lw
        tab.push_back('{32'h0020A223, mk(8'b0010_1000, 3'b001, 4'b0100)}); // sw
        tab.push_back('{32'h00208063, mk(8'b0000_0010, 3'b010, 4'b1000)}); // beq
        tab.push_back('{32'h123450B7, mk(8'b0110_0000, 3'b011, 4'b1011)}); // lui
        tab.push_back('{32'h00001097, mk(8'b0110_0000, 3'b011, 4'b0100)}); // auipc
        tab.push_back('{32'h000000EF, mk(8'b0110_0001, 3'b100, 4'b0100)}); // jal
        tab.push_back('{32'h000100E7, mk(8'b0110_0001, 3'b000, 4'b0100)}); // jalr
        tab.push_back('{32'h0000007F, ill});                               // unknown opcode
        tab.push_back('{32'h023100B3, c_muldiv ? mk(8'b0100_0000, 3'b000, 4'b1100) : ill}); // mul
        tab.push_back('{32'h023140B3, c_muldiv ? mk(8'b0100_0000, 3'b000, 4'b1110) : ill}); // div

        // Asynchronous reset: outputs must clear before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        mid();
        chk("ready_after_reset", in_ready, 1'b1);
        adv();

        // Directed decode table, each instruction followed by an idle cycle.
        for (int i = 0; i < tab.size(); i++) begin
            drive(1'b1, tab[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            mid();
            chk($sformatf("tab%0d_ctrl", i), dut_dec(), tab[i].exp);
            chk($sformatf("tab%0d_valid", i), out_valid, 1'b1);
            adv();
        end

        // Load-use: lw x5 then add x6,x5,x2 -> one stall, add two cycles behind.
        drive(1'b1, 32'h0000A283, 32'h300, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00228333, 32'h304, 1'b1, 1'b0);
        mid();
        chk("lu_stall_ready", in_ready, 1'b0);
        chk("lu_lw_out_rd", out_rd, 5'd5);
        adv();
        mid();
        chk("lu_release_ready", in_ready, 1'b1);
        adv();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        mid();
        chk("lu_add_valid", out_valid, 1'b1);
        chk("lu_add_rd", out_rd, 5'd6);
        chk("lu_add_pc", out_pc, 32'h304);
        adv();

        // Backpressure: bundle and pc frozen, input held off.
        drive(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_ready", in_ready, 1'b0);
            chk("bp_pc", out_pc, 32'h200);
            chk("bp_alu", out_alu_ctrl, 4'b0100);
            adv();
        end

        // Flush with a held bundle and a pending input: both vanish.
        drive(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b1);
        mid();
        chk("flush_ready", in_ready, 1'b0);
        adv();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        mid();
        chk("flush_valid", out_valid, 1'b0);
        adv();

        // Random stream against the model.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            tick();
        end

        // Mid-run asynchronous reset.
        rst_n = 1'b0;
        #1 chk_reset_outputs("reset_midrun");
        m_valid = 1'b0;
        m_lu    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        mid();
        chk("ready_after_reset2", in_ready, 1'b1);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of PC path (32 or 64).
REQ-002 Parameter ALU_W, default 4, width of alu_ctrl.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; its ports are listed below.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard held/incoming instruction.
- in_valid  in  1  instr/pc valid.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- out_alu_ctrl  out  ALU_W  ALU operation.
- out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_jump  out  1 each  control bits.
- out_illegal  out  1  instruction not decodable.

Function
REQ-004 The stage SHALL register the decoded bundle with exactly 1-cycle latency: bundle loads on in_valid && in_ready.
REQ-005 in_ready SHALL = (!out_valid || out_ready) && !hazard && !flush.
REQ-006 out_valid SHALL set on load, clear on out_ready when no new load, and hold bundle stable while out_valid && !out_ready.
REQ-007 ALU codes: ADD 0100, SUB 1000, OR 0010, AND 0001, XOR 0011, SLL 0101, SRL 0110, SRA 0111, SLT 1001, SLTU 1010, PASSB 1011.
REQ-008 Full RV32I decode: R/I ALU ops including shifts and SLT(U); LUI uses PASSB + alu_src=1; AUIPC uses ADD; JAL/JALR jump=1, reg_write=1; branches branch=1, SUB; loads/stores as before.
REQ-009 R-type funct7 SHALL be 0000000, or 0100000 only for funct3 000/101; SLLI funct7=0000000; SRLI/SRAI 0000000/0100000; else illegal.
REQ-010 Unknown opcode or REQ-009 violation: out_illegal=1, reg_write/mem_read/mem_write/branch/jump=0, instruction still passed with out_valid=1.
REQ-011 Load-use tracker: on output transfer of a load with rd!=0, lu_valid=1, lu_rd=rd; lu_valid clears at the following edge unconditionally.
REQ-012 hazard = in_valid && lu_valid && ((uses_rs1 && rs1==lu_rd) || (uses_rs2 && rs2==lu_rd)); uses_rs2 only for R, S, B; uses_rs1 false for LUI, AUIPC, JAL.
REQ-013 Hazard SHALL stall input exactly one cycle; no bundle enters that cycle.
REQ-014 flush SHALL clear out_valid and lu_valid at next edge, drop in-flight input; flush wins over simultaneous load/transfer.

Reset
REQ-015 On rst_n low, immediately: out_valid=0, lu_valid=0, all out_* control bits and fields 0, out_alu_ctrl=0100, out_pc=0.
REQ-016 First edge after deassertion, in_ready SHALL be 1 when flush=0.

Configuration
REQ-017 With DECODE_MULDIV_EN defined, R-type funct7=0000001 decodes M ops: MUL 1100, MULH 1101, DIV 1110, REM 1111 (MULHSU/MULHU/DIVU/REMU map to same codes plus out_illegal=0); without it, funct7=0000001 is illegal.

Structure
REQ-018 Package riscv_ctrl_pkg SHALL hold opcode constants, ALU code constants, imm_sel constants and the control bundle struct.
REQ-019 Combinational decoding SHALL be sub-module ctrl_decode (instr in, bundle + uses_rs1/uses_rs2 out); decode_stage holds registers, handshake, hazard.

Verification
REQ-020 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0100, reg_write=1, rd=3.
REQ-021 lw x5,0(x1) then add x6,x5,x2 back-to-back -> in_ready=0 one cycle, add emerges 2 cycles after lw.
REQ-022 out_ready=0 for 3 cycles with valid bundle -> bundle/out_pc unchanged, in_ready=0.
REQ-023 0x0000007F -> out_illegal=1, reg_write=0, out_valid=1; sra funct7=0100000 -> alu_ctrl=0111.
REQ-024 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input dropped.
REQ-025 mul x1,x2,x3 (0x023100B3) -> alu_ctrl=1100 with DECODE_MULDIV_EN, out_illegal=1 without.
